// File: rtl/mine_neighbour_counter.sv
// Mine neighbour counter: for a queried cell, reports whether it holds a mine
// and how many of its 8 neighbours hold mines. One neighbour is visited per
// clock, so every in-range query has the same latency wherever the cell lies.
module mine_neighbour_counter #(
    parameter int EASY_DIM   = 8,
    parameter int MEDIUM_DIM = 10,
    parameter int HARD_DIM   = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [1:0]                               level,
    input  logic [4:0]                               dimension_size,
    input  logic                                     req,
    input  logic [4:0]                               x_in,
    input  logic [4:0]                               y_in,
    input  logic [EASY_DIM-1:0][EASY_DIM-1:0]        array_easy_in,
    input  logic [MEDIUM_DIM-1:0][MEDIUM_DIM-1:0]    array_medium_in,
    input  logic [HARD_DIM-1:0][HARD_DIM-1:0]        array_hard_in,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     is_mine,
    output logic [3:0]                               mine_count,
    output logic                                     oob
);

    localparam int EW = $clog2(EASY_DIM);
    localparam int MW = $clog2(MEDIUM_DIM);
    localparam int HW = $clog2(HARD_DIM);
    localparam logic [5:0] EASY_L   = 6'(EASY_DIM);
    localparam logic [5:0] MEDIUM_L = 6'(MEDIUM_DIM);
    localparam logic [5:0] HARD_L   = 6'(HARD_DIM);

    typedef enum logic [1:0] {IDLE, CENTER, SCAN, DONE} state_t;

    state_t            state, state_nxt;
    logic [4:0]        x_r, y_r, dim_r;
    logic [1:0]        level_r;
    logic              latch;
    logic [3:0]        acc, acc_nxt;
    logic [2:0]        idx, idx_nxt;
    logic              centre_r, centre_nxt;
    logic              oob_r, oob_nxt;
    logic [5:0]        phys;
    logic              centre_oob;
    logic signed [5:0] nx, ny, dim_s;
    logic              nb_in, nb_bit;

    // Column offset of neighbour idx: the scan walks columns -1, 0, +1.
    function automatic logic signed [5:0] dx_of(input logic [2:0] i);
        if (i <= 3'd2)      return -6'sd1;
        else if (i <= 3'd4) return 6'sd0;
        else                return 6'sd1;
    endfunction

    // Row offset of neighbour idx; the centre (0,0) is skipped.
    function automatic logic signed [5:0] dy_of(input logic [2:0] i);
        case (i)
            3'd0, 3'd3, 3'd5: return -6'sd1;
            3'd1, 3'd6:       return 6'sd0;
            default:          return 6'sd1;
        endcase
    endfunction

    // Mine bit of the array chosen by lvl; cells outside the physical array read 0.
    function automatic logic cell_bit(input logic [1:0] lvl, input logic [4:0] cx,
                                      input logic [4:0] cy);
        case (lvl)
            2'd3: return ({1'b0, cx} < HARD_L) && ({1'b0, cy} < HARD_L) &&
                         array_hard_in[cx[HW-1:0]][cy[HW-1:0]];
            2'd2: return ({1'b0, cx} < MEDIUM_L) && ({1'b0, cy} < MEDIUM_L) &&
                         array_medium_in[cx[MW-1:0]][cy[MW-1:0]];
            default: return ({1'b0, cx} < EASY_L) && ({1'b0, cy} < EASY_L) &&
                            array_easy_in[cx[EW-1:0]][cy[EW-1:0]];
        endcase
    endfunction

    // Range check of the latched query and the current neighbour's contribution.
    always_comb begin
        case (level_r)
            2'd3:    phys = HARD_L;
            2'd2:    phys = MEDIUM_L;
            default: phys = EASY_L;
        endcase
        centre_oob = (x_r >= dim_r) || (y_r >= dim_r) || ({1'b0, dim_r} > phys);
        dim_s  = $signed({1'b0, dim_r});
        nx     = $signed({1'b0, x_r}) + dx_of(idx);
        ny     = $signed({1'b0, y_r}) + dy_of(idx);
        nb_in  = (nx >= 6'sd0) && (ny >= 6'sd0) && (nx < dim_s) && (ny < dim_s);
        nb_bit = nb_in && cell_bit(level_r, nx[4:0], ny[4:0]);
    end

    // Next-state and next-accumulator logic.
    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        idx_nxt    = idx;
        centre_nxt = centre_r;
        oob_nxt    = oob_r;
        latch      = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    latch      = 1'b1;
                    acc_nxt    = 4'd0;
                    idx_nxt    = 3'd0;
                    centre_nxt = 1'b0;
                    oob_nxt    = 1'b0;
                    state_nxt  = CENTER;
                end
            end
            CENTER: begin
                if (centre_oob) begin
                    centre_nxt = 1'b0;
                    acc_nxt    = 4'd0;
                    oob_nxt    = 1'b1;
                    state_nxt  = DONE;
                end else begin
                    centre_nxt = cell_bit(level_r, x_r, y_r);
                    idx_nxt    = 3'd0;
                    state_nxt  = SCAN;
                end
            end
            SCAN: begin
                acc_nxt = acc + {3'b000, nb_bit};
                if (idx == 3'd7) state_nxt = DONE;
                else             idx_nxt   = idx + 3'd1;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, accumulator and registered outputs; results commit when DONE is left.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= 4'd0;
            idx        <= 3'd0;
            centre_r   <= 1'b0;
            oob_r      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            is_mine    <= 1'b0;
            mine_count <= 4'd0;
            oob        <= 1'b0;
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            idx      <= idx_nxt;
            centre_r <= centre_nxt;
            oob_r    <= oob_nxt;
            busy     <= (state != IDLE);
            done     <= (state == DONE);
            if (state == DONE) begin
                is_mine    <= centre_r;
                mine_count <= acc;
                oob        <= oob_r;
            end
        end
    end

    // Query operands captured on accept; later input changes do not disturb a scan.
    always_ff @(posedge clk) begin
        if (latch) begin
            x_r     <= x_in;
            y_r     <= y_in;
            level_r <= level;
            dim_r   <= dimension_size;
        end
    end

endmodule

// File: tb/tb_mine_neighbour_counter.sv
// Directed bench for mine_neighbour_counter.
module tb_mine_neighbour_counter;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           level;
    logic [4:0]           dimension_size;
    logic                 req;
    logic [4:0]           x_in, y_in;
    logic [7:0][7:0]      ae;
    logic [9:0][9:0]      am;
    logic [15:0][15:0]    ah;
    logic                 busy, done, is_mine, oob;
    logic [3:0]           mine_count;

    int pass_cnt = 0;
    int total_cnt = 0;
    int lat, bcnt, dcnt;

    mine_neighbour_counter #(.EASY_DIM(8), .MEDIUM_DIM(10), .HARD_DIM(16)) dut (
        .clk(clk), .rst(rst), .level(level), .dimension_size(dimension_size),
        .req(req), .x_in(x_in), .y_in(y_in),
        .array_easy_in(ae), .array_medium_in(am), .array_hard_in(ah),
        .busy(busy), .done(done), .is_mine(is_mine), .mine_count(mine_count), .oob(oob)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Issue one query, then watch 20 cycles: latency to first done, busy cycles, done pulses.
    // With disturb set, a second req with other coordinates and level is pulsed mid-scan.
    task automatic run_query(input logic [1:0] lv, input logic [4:0] dim, input logic [4:0] qx,
                             input logic [4:0] qy, input bit disturb,
                             output int l, output int b, output int d);
        @(negedge clk);
        level = lv; dimension_size = dim; x_in = qx; y_in = qy; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        l = -1; b = 0; d = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy) b++;
            if (done) begin
                d++;
                if (l < 0) l = k;
            end
            if (disturb && k == 4) begin
                req = 1'b1; x_in = 5'd0; y_in = 5'd0; level = 2'd3; dimension_size = 5'd16;
            end
            if (disturb && k == 5) req = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; level = 2'd0; dimension_size = 5'd8;
        x_in = 5'd0; y_in = 5'd0; ae = '0; am = '0; ah = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_is_mine", is_mine, 0);
        chk("reset_count", mine_count, 0);
        chk("reset_oob", oob, 0);
        rst = 1'b0;

        // Empty easy board, interior cell.
        run_query(2'd0, 5'd8, 5'd3, 5'd3, 1'b0, lat, bcnt, dcnt);
        chk("empty_latency", lat, 10);
        chk("empty_busy_cycles", bcnt, 10);
        chk("empty_done_pulses", dcnt, 1);
        chk("empty_is_mine", is_mine, 0);
        chk("empty_count", mine_count, 0);
        chk("empty_oob", oob, 0);

        // Corner cluster on easy: centre mined, 3 in-range neighbours mined.
        ae[0][0] = 1'b1; ae[0][1] = 1'b1; ae[1][0] = 1'b1; ae[1][1] = 1'b1;
        run_query(2'd0, 5'd8, 5'd0, 5'd0, 1'b0, lat, bcnt, dcnt);
        chk("corner_latency", lat, 10);
        chk("corner_is_mine", is_mine, 1);
        chk("corner_count", mine_count, 3);
        chk("corner_oob", oob, 0);

        // Fully mined hard board: interior and far corner.
        ah = '1;
        run_query(2'd3, 5'd16, 5'd7, 5'd7, 1'b0, lat, bcnt, dcnt);
        chk("hard_mid_count", mine_count, 8);
        chk("hard_mid_is_mine", is_mine, 1);
        run_query(2'd3, 5'd16, 5'd15, 5'd15, 1'b0, lat, bcnt, dcnt);
        chk("hard_corner_count", mine_count, 3);
        chk("hard_corner_latency", lat, 10);

        // Medium: in-range corner on a full board, then an out-of-range column.
        am = '1;
        run_query(2'd2, 5'd10, 5'd9, 5'd9, 1'b0, lat, bcnt, dcnt);
        chk("medium_corner_count", mine_count, 3);
        chk("medium_corner_oob", oob, 0);
        run_query(2'd2, 5'd10, 5'd10, 5'd2, 1'b0, lat, bcnt, dcnt);
        chk("medium_oob_flag", oob, 1);
        chk("medium_oob_count", mine_count, 0);
        chk("medium_oob_is_mine", is_mine, 0);
        chk("medium_oob_latency", lat, 2);
        chk("medium_oob_busy_cycles", bcnt, 2);

        // Easy centre of the cluster, then an easy board claiming side 10.
        run_query(2'd0, 5'd8, 5'd1, 5'd1, 1'b0, lat, bcnt, dcnt);
        chk("easy_inner_count", mine_count, 3);
        chk("easy_inner_oob", oob, 0);
        run_query(2'd0, 5'd10, 5'd2, 5'd2, 1'b0, lat, bcnt, dcnt);
        chk("easy_dim10_oob", oob, 1);
        chk("easy_dim10_count", mine_count, 0);

        // Second req during the scan (with level switched to hard) is ignored.
        run_query(2'd0, 5'd8, 5'd5, 5'd5, 1'b1, lat, bcnt, dcnt);
        chk("ignore_latency", lat, 10);
        chk("ignore_done_pulses", dcnt, 1);
        chk("ignore_count", mine_count, 0);
        chk("ignore_is_mine", is_mine, 0);

        // Leave non-zero held results, then reset in the middle of the scan.
        run_query(2'd0, 5'd8, 5'd0, 5'd0, 1'b0, lat, bcnt, dcnt);
        chk("pre_reset_count", mine_count, 3);
        @(negedge clk);
        level = 2'd0; dimension_size = 5'd8; x_in = 5'd0; y_in = 5'd0; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("midreset_busy", busy, 0);
        chk("midreset_count", mine_count, 0);
        chk("midreset_is_mine", is_mine, 0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("midreset_no_done", dcnt, 0);
        run_query(2'd0, 5'd8, 5'd0, 5'd0, 1'b0, lat, bcnt, dcnt);
        chk("post_reset_latency", lat, 10);
        chk("post_reset_count", mine_count, 3);
        chk("post_reset_is_mine", is_mine, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mine_neighbour_counter.md
Name: mine_neighbour_counter

Overview:
Reads the mine arrays produced by the board generator and, on request, returns whether a given cell holds a mine and how many of its 8 neighbours hold mines. The reveal/display logic uses it to obtain the number drawn on an uncovered cell. It uses a single req/done handshake. It scans one neighbour per clock, so latency is fixed regardless of position.

Parameters:
EASY_DIM, 8, physical size of the easy array
MEDIUM_DIM, 10, physical size of the medium array
HARD_DIM, 16, physical size of the hard array

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
level  input  2  3 = hard, 2 = medium, other values = easy; latched on req accept
dimension_size  input  5  active board side length; latched on req accept
req  input  1  query request; sampled only in IDLE
x_in  input  5  query column index (first array index); latched on accept
y_in  input  5  query row index (second array index); latched on accept
array_easy_in  input  1 x [7:0][7:0]  easy mine map, '1 = mine
array_medium_in  input  1 x [9:0][9:0]  medium mine map
array_hard_in  input  1 x [15:0][15:0]  hard mine map
busy  output  1  high from accept until the end of the DONE cycle
done  output  1  one-cycle pulse; results valid in this cycle and held afterwards
is_mine  output  1  queried cell holds a mine
mine_count  output  4  number of mined neighbours, 0..8
oob  output  1  query coordinate was out of range

Behaviour:
- Reset (async, active-high): state IDLE. busy, done, is_mine, oob = 0. mine_count = 0. Internal accumulator and neighbour index = 0. Reset mid-query aborts with no done pulse.
- States: IDLE -> CENTER -> SCAN (8 cycles) -> DONE -> IDLE.
- IDLE: busy = 0. On a clock edge with req = 1: latch x_in, y_in, level, dimension_size; clear accumulator; go to CENTER. busy rises in the next cycle.
- CENTER (1 cycle):
  - Range check: x >= dimension_size, or y >= dimension_size, or dimension_size > physical size of the selected array → oob condition. In that case record is_mine = 0, accumulator = 0, oob = 1, and jump directly to DONE (latency 2 cycles).
  - Otherwise record the centre bit as is_mine and go to SCAN with index 0.
- SCAN: index 0..7 visits offsets (dx,dy) = (-1,-1), (-1,0), (-1,1), (0,-1), (0,1), (1,-1), (1,0), (1,1).
  - Neighbour coordinates are computed in 6-bit signed arithmetic.
  - A neighbour with a coordinate < 0 or >= latched dimension_size contributes 0 but still consumes its cycle.
  - An in-range neighbour adds its array bit to the accumulator.
  - After index 7, go to DONE.
- DONE (1 cycle): done = 1. mine_count, is_mine and oob update from the internal values at the entry edge of this cycle. The outputs then hold until the next DONE. Next state is IDLE.
- Latency: req sampled at edge N → done high in the cycle after edge N+10 (1 CENTER + 8 SCAN + DONE). For oob queries, done is high after edge N+2.
- A req arriving while busy is ignored. It is not queued.
- A req held high continuously restarts a new query in the first IDLE cycle after DONE.
- Array inputs are read live, with no snapshot. Callers query only after board generation has completed; changes during a scan are not covered.
- The accumulator is 4 bits and cannot overflow: the maximum is 8.
- Array selection uses the latched level; changes to level mid-query have no effect.

Test Plan:
- Easy, dimension_size 8, all-zero arrays, req (3,3) → done exactly 10 cycles after accept; is_mine 0; mine_count 0; oob 0; busy high for 10 cycles.
- Easy, mines at (0,1), (1,0), (1,1) and (0,0), req (0,0) → is_mine 1, mine_count 3, oob 0. Corner out-of-range neighbours are skipped; latency is still 10.
- Hard, dimension_size 16, all cells mined, req (7,7) → mine_count 8, is_mine 1. Req (15,15) → mine_count 3.
- Medium, dimension_size 10, req (10,2) → oob 1, mine_count 0, is_mine 0, done 2 cycles after accept. Easy with dimension_size 10 → oob 1.
- Req pulsed again during SCAN with different coordinates → ignored; results reflect the first query only; exactly one done pulse.
- Assert rst during SCAN index 4 → outputs cleared immediately, no done pulse. The next req after rst release completes normally with correct results.
